// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: memory-port owner encoding and the default sizing
// constants used by the fetch/data port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH   = 14;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    // Who the read data on m_rdata belongs to in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read memory port between instruction fetch
// and data load/store. Data wins contention unless fetch has been denied
// STARVE_LIMIT cycles in a row. Read data returns one cycle after the grant
// and is steered to the port recorded in the owner register.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction fetch port
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    // data port
    input  logic                  d_req,
    input  logic [3:0]            d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    // pipeline control
    input  logic                  flush,
    // memory side
    output logic                  m_en,
    output logic [3:0]            m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    owner_e           owner_q, owner_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             starved;

    assign starved = (starve_cnt == CNT_MAX);

    // Grant selection: data has priority unless fetch is starved; nothing is
    // granted while reset is held.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (f_req && (!d_req || starved)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory command mux: drive the granted port's request, zeros when idle.
    always_comb begin
        m_en    = f_gnt | d_gnt;
        m_we    = 4'b0000;
        m_addr  = '0;
        m_wdata = 32'h0000_0000;
        if (f_gnt) begin
            m_addr = f_addr;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Next owner and starvation count. A fetch granted under flush is
    // recorded as NONE so its data never surfaces; stores never respond.
    always_comb begin
        owner_nxt  = OWN_NONE;
        starve_nxt = '0;
        if (f_gnt && !flush) begin
            owner_nxt = OWN_FETCH;
        end else if (d_gnt && (d_we == 4'b0000)) begin
            owner_nxt = OWN_LOAD;
        end
        if (f_req && !f_gnt) begin
            starve_nxt = starved ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    // Owner and starvation registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples its pre-edge inputs regardless of order.
            owner_q    <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Response steering: data passes straight through, validity comes from
    // the owner; a flush in the response cycle also hides a fetch response.
    assign f_rvalid = (owner_q == OWN_FETCH) && !flush;
    assign d_rvalid = (owner_q == OWN_LOAD);
    assign f_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_mem_port_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req, flush;
    logic [AW-1:0] f_addr, d_addr, m_addr;
    logic [3:0]    d_we, m_we;
    logic [31:0]   d_wdata, m_wdata, m_rdata, f_rdata, d_rdata;
    logic          f_gnt, d_gnt, f_rvalid, d_rvalid, m_en;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .flush(flush),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus, applied on the falling edge.
    task automatic apply(input logic rs, input logic fr, input logic [AW-1:0] fa,
                         input logic dr, input logic [3:0] we, input logic [AW-1:0] da,
                         input logic [31:0] wd, input logic fl, input logic [31:0] rd);
        @(negedge clk);
        rst = rs; f_req = fr; f_addr = fa; d_req = dr; d_we = we;
        d_addr = da; d_wdata = wd; flush = fl; m_rdata = rd;
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic ef, input logic ed);
        chk({tag, ".f_gnt"}, {31'd0, f_gnt}, {31'd0, ef});
        chk({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, ed});
    endtask

    task automatic idle(input logic [31:0] rd);
        apply(1'b1, 1'b0, '0, 1'b0, 4'h0, '0, 32'h0, 1'b0, rd);
    endtask

    initial begin
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0; flush = 1'b0;
        f_addr = '0; d_addr = '0; d_we = 4'h0; d_wdata = 32'h0; m_rdata = 32'h0;

        // Reset held with both ports requesting: everything quiet.
        apply(1'b0, 1'b1, 14'h010, 1'b1, 4'h0, 14'h020, 32'h0, 1'b0, 32'h0);
        chk_gnt("rst", 1'b0, 1'b0);
        chk("rst.m_en", {31'd0, m_en}, 32'd0);
        chk("rst.m_we", {28'd0, m_we}, 32'd0);
        chk("rst.f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst.d_rvalid", {31'd0, d_rvalid}, 32'd0);

        // Fetch only, granted in the first cycle after release.
        apply(1'b1, 1'b1, 14'h010, 1'b0, 4'h0, '0, 32'h0, 1'b0, 32'h0);
        chk_gnt("fetch", 1'b1, 1'b0);
        chk("fetch.m_en", {31'd0, m_en}, 32'd1);
        chk("fetch.m_addr", {18'd0, m_addr}, 32'h010);
        idle(32'h00A0_0093);
        chk("fetch.f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("fetch.f_rdata", f_rdata, 32'h00A0_0093);
        chk("fetch.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("idle.m_en", {31'd0, m_en}, 32'd0);
        chk("idle.m_addr", {18'd0, m_addr}, 32'h0);

        // Contention: data wins four times, then starved fetch, then data.
        for (int c = 1; c <= 6; c++) begin
            apply(1'b1, 1'b1, 14'h100, 1'b1, 4'h0, 14'h200, 32'h0, 1'b0, 32'h0);
            chk_gnt($sformatf("cont%0d", c), c == 5, c != 5);
            chk($sformatf("cont%0d.m_addr", c), {18'd0, m_addr}, (c == 5) ? 32'h100 : 32'h200);
            if (c == 6) begin
                chk("cont6.f_rvalid", {31'd0, f_rvalid}, 32'd1);
                chk("cont6.d_rvalid", {31'd0, d_rvalid}, 32'd0);
            end
        end
        idle(32'h0);
        chk("cont.last_load", {31'd0, d_rvalid}, 32'd1);

        // Store: byte mask and data reach the memory, no response.
        apply(1'b1, 1'b0, '0, 1'b1, 4'b0011, 14'h020, 32'hDEAD_BEEF, 1'b0, 32'h0);
        chk_gnt("store", 1'b0, 1'b1);
        chk("store.m_we", {28'd0, m_we}, 32'h3);
        chk("store.m_addr", {18'd0, m_addr}, 32'h020);
        chk("store.m_wdata", m_wdata, 32'hDEAD_BEEF);
        idle(32'h5555_5555);
        chk("store.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("store.f_rvalid", {31'd0, f_rvalid}, 32'd0);

        // Flush in the response cycle of a fetch, with a load granted then.
        apply(1'b1, 1'b1, 14'h030, 1'b0, 4'h0, '0, 32'h0, 1'b0, 32'h0);
        chk_gnt("flushA", 1'b1, 1'b0);
        apply(1'b1, 1'b0, '0, 1'b1, 4'h0, 14'h040, 32'h0, 1'b1, 32'h9999_9999);
        chk("flushA.f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk_gnt("flushA.load", 1'b0, 1'b1);
        idle(32'h1234_5678);
        chk("flushA.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("flushA.d_rdata", d_rdata, 32'h1234_5678);
        chk("flushA.f_rvalid2", {31'd0, f_rvalid}, 32'd0);

        // Flush in the same cycle as the fetch grant.
        apply(1'b1, 1'b1, 14'h034, 1'b0, 4'h0, '0, 32'h0, 1'b1, 32'h0);
        chk_gnt("flushB", 1'b1, 1'b0);
        idle(32'h7777_7777);
        chk("flushB.f_rvalid", {31'd0, f_rvalid}, 32'd0);

        // Back-to-back fetch, load, fetch.
        apply(1'b1, 1'b1, 14'h050, 1'b0, 4'h0, '0, 32'h0, 1'b0, 32'h0);
        chk_gnt("b2b1", 1'b1, 1'b0);
        apply(1'b1, 1'b0, '0, 1'b1, 4'h0, 14'h060, 32'h0, 1'b0, 32'h1111_1111);
        chk_gnt("b2b2", 1'b0, 1'b1);
        chk("b2b2.f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("b2b2.f_rdata", f_rdata, 32'h1111_1111);
        apply(1'b1, 1'b1, 14'h054, 1'b0, 4'h0, '0, 32'h0, 1'b0, 32'h2222_2222);
        chk_gnt("b2b3", 1'b1, 1'b0);
        chk("b2b3.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("b2b3.d_rdata", d_rdata, 32'h2222_2222);
        chk("b2b3.f_rvalid", {31'd0, f_rvalid}, 32'd0);
        idle(32'h3333_3333);
        chk("b2b4.f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("b2b4.f_rdata", f_rdata, 32'h3333_3333);
        chk("b2b4.d_rvalid", {31'd0, d_rvalid}, 32'd0);

        // Reset mid-access: starve count at 3 and a load in flight.
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b1, 14'h070, 1'b1, 4'h0, 14'h080, 32'h0, 1'b0, 32'h0);
        end
        chk("mid.starve_pre", 32'(dut.starve_cnt), 32'd2);
        chk_gnt("mid.load", 1'b0, 1'b1);
        apply(1'b0, 1'b1, 14'h070, 1'b1, 4'h0, 14'h080, 32'h0, 1'b0, 32'hAAAA_AAAA);
        chk("mid.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("mid.starve_cnt", 32'(dut.starve_cnt), 32'd0);
        chk_gnt("mid", 1'b0, 1'b0);
        chk("mid.m_en", {31'd0, m_en}, 32'd0);
        chk("mid.m_addr", {18'd0, m_addr}, 32'h0);
        idle(32'hBBBB_BBBB);
        chk("mid.post_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("mid.post_f_rvalid", {31'd0, f_rvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
